// File: rtl/cdc_xfer_ctrl_pkg.sv
// Shared types and helpers for the source-domain CDC transfer sequencer.
// Holds the FSM encoding, counter sizing and the round-robin search function.
package cdc_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;
  localparam int SETUP_W     = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT + 1);

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Search starts at ptr, ascends and wraps at n; returns ptr when nothing is set.
  function automatic logic [IDX_W-1:0] next_rr(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int                 n);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      sel = IDX_W'(idx);
      if (i < n && !found && req[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/cdc_xfer_ctrl_rr_arbiter.sv
// Combinational round-robin pick among the active requesters.
module rr_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   win,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   ptr_ext;
  logic [IDX_W-1:0]   win_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = IDX_W'(ptr);
    win_ext                = next_rr(req_ext, ptr_ext, NUM_REQ);
    win                    = PTR_W'(win_ext);
    any_req                = |req;
  end

endmodule

// File: rtl/cdc_xfer_ctrl.sv
// Source-side sequencer for a toggle-handshake multi-bit crossing: arbitrates
// requesters, holds the word stable, flips the request toggle, awaits the ack.
module cdc_xfer_ctrl
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 24,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         xfer_data,
  output logic                      xfer_req_tgl,
  input  logic                      xfer_ack_tgl,
  output logic                      busy,
  output logic                      fault
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  localparam logic [SETUP_W-1:0] SETUP_LD = SETUP_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
  logic                tgl_q, tgl_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic [PTR_W-1:0]    arb_win;
  logic                arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (arb_win),
    .any_req (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    done_d      = '0;
    xfer_data_d = xfer_data_q;
    tgl_d       = tgl_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          win_d       = arb_win;
          xfer_data_d = req_data[int'(arb_win)*DATA_W +: DATA_W];
          setup_cnt_d = SETUP_LD;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Flip on the cycle the count reaches zero, so the toggle is seen
        // SETUP_CYCLES cycles after the word was loaded.
        setup_cnt_d = setup_cnt_q - SETUP_W'(1);
        if (setup_cnt_q <= SETUP_W'(1)) begin
          tgl_d     = ~tgl_q;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (xfer_ack_tgl == tgl_q) begin
          done_d[win_q] = 1'b1;
          ptr_d         = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
          state_d       = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      done_q      <= '0;
      xfer_data_q <= '0;
      tgl_q       <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      done_q      <= done_d;
      xfer_data_q <= xfer_data_d;
      tgl_q       <= tgl_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign done         = done_q;
  assign xfer_data    = xfer_data_q;
  assign xfer_req_tgl = tgl_q;
  assign busy         = busy_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_cdc_xfer_ctrl.sv
// Directed bench for cdc_xfer_ctrl with a done-pulse scoreboard and a
// two-cycle far-side ack loopback that can be overridden by hand.
module tb_cdc_xfer_ctrl;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 24;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         xfer_data;
  logic                      xfer_req_tgl;
  logic                      xfer_ack_tgl;
  logic                      busy;
  logic                      fault;

  logic [DATA_W-1:0] w0, w1;
  logic              ack_loop, ack_man;
  logic              far_d1, far_d2;
  int                cyc;
  int                n_vec, n_err;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t exp_q[$];

  assign req_data     = {w1, w0};
  assign xfer_ack_tgl = ack_loop ? far_d2 : ack_man;

  cdc_xfer_ctrl #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .SETUP_CYCLES   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .done         (done),
    .xfer_data    (xfer_data),
    .xfer_req_tgl (xfer_req_tgl),
    .xfer_ack_tgl (xfer_ack_tgl),
    .busy         (busy),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Far side: two-flop return path, reset together with the source side.
  always @(posedge clk) begin
    if (rst) begin
      far_d1 <= 1'b0;
      far_d2 <= 1'b0;
    end else begin
      far_d1 <= xfer_req_tgl;
      far_d2 <= far_d1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int idx, input logic [DATA_W-1:0] d, input int c);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t             e;
        logic [NUM_REQ-1:0] oh;
        e  = exp_q.pop_front();
        oh = NUM_REQ'(1) << e.idx;
        chk("done_index", 32'(done), 32'(oh));
        chk("done_data", 32'(xfer_data), 32'(e.data));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    req      = '0;
    w0       = '0;
    w1       = '0;
    ack_loop = 1'b1;
    ack_man  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(xfer_data), 32'd0);
    chk("rst_tgl", 32'(xfer_req_tgl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // Single request with 2-cycle ack loopback.
    @(negedge clk);
    c   = cyc;
    w0  = 24'hABCDEF;
    req = 2'b01;
    push(0, 24'hABCDEF, c + 6);
    wait_to(c + 1);
    chk("single_data_c1", 32'(xfer_data), 32'hABCDEF);
    chk("single_busy_c1", 32'(busy), 32'd1);
    wait_to(c + 2);
    chk("single_tgl_c2", 32'(xfer_req_tgl), 32'd0);
    wait_to(c + 3);
    chk("single_tgl_c3", 32'(xfer_req_tgl), 32'd1);
    wait_to(c + 6);
    req = '0;

    // Reset while waiting for an ack that never comes.
    @(negedge clk);
    ack_loop = 1'b0;
    ack_man  = 1'b1;
    c   = cyc;
    w1  = 24'h123456;
    req = 2'b10;
    wait_to(c + 4);
    chk("rst_mid_data", 32'(xfer_data), 32'h123456);
    chk("rst_mid_tgl", 32'(xfer_req_tgl), 32'd0);
    wait_to(c + 5);
    rst = 1'b1;
    wait_to(c + 6);
    chk("rst_mid_tgl_after", 32'(xfer_req_tgl), 32'd0);
    chk("rst_mid_data_after", 32'(xfer_data), 32'd0);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);
    chk("rst_mid_done_after", 32'(done), 32'd0);
    rst      = 1'b0;
    req      = '0;
    ack_loop = 1'b1;
    ack_man  = 1'b0;

    // Fairness: both held, pointer back at 0 so order is 0,1,0,1.
    @(negedge clk);
    c   = cyc;
    w0  = 24'h111111;
    w1  = 24'h222222;
    req = 2'b11;
    push(0, 24'h111111, c + 6);
    push(1, 24'h222222, c + 12);
    push(0, 24'h111111, c + 18);
    push(1, 24'h222222, c + 24);
    wait_to(c + 7);
    chk("fair_data_w1", 32'(xfer_data), 32'h222222);
    wait_to(c + 13);
    chk("fair_data_w0", 32'(xfer_data), 32'h111111);
    wait_to(c + 24);
    req = '0;

    // Spurious ack flip in IDLE, then a late-matching ack.
    @(negedge clk);
    ack_loop = 1'b0;
    ack_man  = 1'b1;
    repeat (4) @(negedge clk);
    c   = cyc;
    w1  = 24'h5A5A5A;
    req = 2'b10;
    push(1, 24'h5A5A5A, c + 9);
    for (int k = 1; k <= 8; k++) begin
      wait_to(c + k);
      chk("hold_data", 32'(xfer_data), 32'h5A5A5A);
      if (k == 1) ack_man = 1'b0;
      if (k == 3) chk("spur_tgl", 32'(xfer_req_tgl), 32'd1);
      if (k == 8) ack_man = 1'b1;
    end
    wait_to(c + 9);
    chk("hold_data_done", 32'(xfer_data), 32'h5A5A5A);
    req = '0;

    // Timeout: toggle flips to 0, ack held at 1.
    @(negedge clk);
    c   = cyc;
    w0  = 24'h0F0F0F;
    req = 2'b01;
    wait_to(c + 3);
    chk("tmo_tgl", 32'(xfer_req_tgl), 32'd0);
    wait_to(c + 18);
    chk("tmo_fault_early", 32'(fault), 32'd0);
    wait_to(c + 19);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd1);
    w1  = 24'h333333;
    req = 2'b11;
    wait_to(c + 30);
    chk("fault_tgl_hold", 32'(xfer_req_tgl), 32'd0);
    chk("fault_data_hold", 32'(xfer_data), 32'h0F0F0F);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_busy", 32'(busy), 32'd1);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("fault_clr", 32'(fault), 32'd0);
    chk("fault_clr_busy", 32'(busy), 32'd0);
    chk("fault_clr_data", 32'(xfer_data), 32'd0);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    chk("pending_expect", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
